i2s_tx_multi: RTL and testbench

Parametrised I2S/TDM serial audio transmitter with an integrated sample buffer. It is the next generation of the stereo 16-bit output path.
- Accepts whole frames (all channels packed in one word) from the filter stage over an rts/rtr handshake.
- Buffers them in an internal FIFO.
- Serialises them MSB-first on an externally generated sck strobe.
- Reports FIFO underrun (sticky) and buffer fill level to the register file.

---
 rtl/i2s_pkg.sv | 33 +++
 rtl/i2so_frame_fifo.sv | 62 ++++++
 rtl/i2s_tx_multi.sv | 141 ++++++++++++++
 tb/tb_i2s_tx_multi.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared state encoding, word-select timing and parameter checks for the I2S/TDM transmitter.
// Define I2SO_LEFT_JUSTIFIED_EN for left-justified word select; default is I2S one-bit delay.
package i2s_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StFrame = 1'b1
  } i2so_state_e;

  localparam int unsigned DataWMin    = 8;
  localparam int unsigned DataWMax    = 32;
  localparam int unsigned ChannelsMin = 2;
  localparam int unsigned ChannelsMax = 8;

  function automatic bit i2so_params_legal(int unsigned data_w, int unsigned channels);
    return (data_w >= DataWMin) && (data_w <= DataWMax) &&
           (channels >= ChannelsMin) && (channels <= ChannelsMax) && (channels % 2 == 0);
  endfunction

  function automatic bit i2so_depth_legal(int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Word select level while bit b of an n-bit frame is on the wire.
  function automatic logic i2so_ws_at(int unsigned b, int unsigned n);
`ifdef I2SO_LEFT_JUSTIFIED_EN
    return logic'(b >= n / 2);
`else
    return logic'(((b + 1) % n) >= n / 2);
`endif
  endfunction

endpackage

// File: rtl/i2so_frame_fifo.sv
// Synchronous frame FIFO with rts/rtr handshakes on both sides and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module i2so_frame_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH) + 1,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_rts_i,
  output logic             wr_rtr_o,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_rts_o,
  input  logic             rd_rtr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign wr_rtr_o  = (count_q != CntW'(DEPTH));
  assign rd_rts_o  = (count_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign push      = wr_rts_i & wr_rtr_o;
  assign pop       = rd_rtr_i & rd_rts_o;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/i2s_tx_multi.sv
// Buffered I2S/TDM transmitter: frames are queued in a FIFO and shifted out MSB-first on sck strobes.
// Word-select format follows I2SO_LEFT_JUSTIFIED_EN (see i2s_pkg).
module i2s_tx_multi
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sck_transition,
  input  logic                       rf_i2so_en,
  input  logic                       filt_rts,
  output logic                       filt_rtr,
  input  logic [CHANNELS*DATA_W-1:0] filt_data,
  output logic                       i2so_ws,
  output logic                       i2so_sd,
  output logic                       ro_fifo_underrun,
  input  logic                       trig_i2so_underrun_clr,
  output logic [LVL_W-1:0]           ro_fifo_level
);

  localparam int unsigned N    = CHANNELS * DATA_W;
  localparam int unsigned BitW = $clog2(N);
  localparam logic [BitW-1:0] LastBit = BitW'(N - 1);

  if (!i2so_params_legal(DATA_W, CHANNELS) || !i2so_depth_legal(FIFO_DEPTH)) begin : g_bad_params
    $error("i2s_tx_multi: DATA_W, CHANNELS or FIFO_DEPTH out of range");
  end

  i2so_state_e     state_q, state_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [N-1:0]    shift_q, shift_d;
  logic            sd_q, sd_d;
  logic            ws_q, ws_d;
  logic            underrun_q, underrun_d;
  logic            frame_start;
  logic            fifo_pop;
  logic            fifo_valid;
  logic [N-1:0]    fifo_data;

  i2so_frame_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_rts_i  (filt_rts),
    .wr_rtr_o  (filt_rtr),
    .wr_data_i (filt_data),
    .rd_rts_o  (fifo_valid),
    .rd_rtr_i  (fifo_pop),
    .rd_data_o (fifo_data),
    .count_o   (ro_fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_q      <= '0;
      shift_q    <= '0;
      sd_q       <= 1'b0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sd_q       <= sd_d;
      ws_q       <= ws_d;
      underrun_q <= underrun_d;
    end
  end

  // A disable only takes effect at a frame boundary, so frames always complete.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    frame_start = 1'b0;
    if (sck_transition) begin
      unique case (state_q)
        StIdle: begin
          if (rf_i2so_en) begin
            state_d     = StFrame;
            bit_d       = '0;
            frame_start = 1'b1;
          end
        end
        StFrame: begin
          if (bit_q == LastBit) begin
            bit_d = '0;
            if (rf_i2so_en) begin
              frame_start = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    shift_d    = shift_q;
    sd_d       = sd_q;
    ws_d       = ws_q;
    fifo_pop   = 1'b0;
    underrun_d = underrun_q;
    if (trig_i2so_underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (sck_transition) begin
      if (frame_start) begin
        fifo_pop = fifo_valid;
        shift_d  = fifo_valid ? fifo_data : '0;
        if (!fifo_valid) begin
          underrun_d = 1'b1;
        end
      end else if (state_q == StFrame) begin
        shift_d = {shift_q[N-2:0], 1'b0};
      end
      if (state_d == StFrame) begin
        sd_d = shift_d[N-1];
        ws_d = i2so_ws_at(32'(bit_d), N);
      end else begin
        sd_d = 1'b0;
        ws_d = 1'b0;
      end
    end
  end

  assign i2so_sd          = sd_q;
  assign i2so_ws          = ws_q;
  assign ro_fifo_underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Self-checking bench for i2s_tx_multi: directed table and sequences plus random traffic vs a queue model.
// Honours I2SO_LEFT_JUSTIFIED_EN for the expected word-select timing.
module tb_i2s_tx_multi;

  localparam int N     = 32;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic        en = 1'b0;
  logic        rts = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] data = '0;
  logic        filt_rtr, ws, sd, uf;
  logic [3:0]  lvl;

  logic        en_t = 1'b0;
  logic        rts_t = 1'b0;
  logic [31:0] data_t = '0;
  logic        rtr_t, ws_t, sd_t, uf_t;
  logic [2:0]  lvl_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx_multi #(.DATA_W(16), .CHANNELS(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sck_transition(strobe), .rf_i2so_en(en),
    .filt_rts(rts), .filt_rtr(filt_rtr), .filt_data(data),
    .i2so_ws(ws), .i2so_sd(sd), .ro_fifo_underrun(uf),
    .trig_i2so_underrun_clr(clr), .ro_fifo_level(lvl)
  );

  i2s_tx_multi #(.DATA_W(8), .CHANNELS(4), .FIFO_DEPTH(4)) dut_tdm (
    .clk(clk), .rst(rst), .sck_transition(strobe), .rf_i2so_en(en_t),
    .filt_rts(rts_t), .filt_rtr(rtr_t), .filt_data(data_t),
    .i2so_ws(ws_t), .i2so_sd(sd_t), .ro_fifo_underrun(uf_t),
    .trig_i2so_underrun_clr(1'b0), .ro_fifo_level(lvl_t)
  );

  // Reference model: a frame queue plus the position inside the frame on the wire.
  logic [31:0] mq[$];
  bit          m_active;
  int          m_b;
  logic [31:0] m_frame;
  bit          m_uf, m_sd, m_ws;

  function automatic bit exp_ws(int b);
`ifdef I2SO_LEFT_JUSTIFIED_EN
    return b >= N / 2;
`else
    return ((b + 1) % N) >= N / 2;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_b      = 0;
    m_frame  = '0;
    m_uf     = 0;
    m_sd     = 0;
    m_ws     = 0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit r, input logic [31:0] d,
                            input bit c);
    bit          was_empty = (mq.size() == 0);
    bit          can_push  = (mq.size() < DEPTH);
    bit          fs;
    logic [31:0] popped = '0;
    fs = s && e && (!m_active || m_b == N - 1);
    if (fs && !was_empty) popped = mq.pop_front();
    if (r && can_push) mq.push_back(d);
    if (c) m_uf = 0;
    if (fs && was_empty) m_uf = 1;
    if (s) begin
      if (fs) begin
        m_active = 1;
        m_b      = 0;
        m_frame  = popped;
      end else if (m_active) begin
        if (m_b == N - 1) m_active = 0;
        else m_b++;
      end
      m_sd = m_active ? m_frame[N-1-m_b] : 1'b0;
      m_ws = m_active ? exp_ws(m_b) : 1'b0;
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge and compare.
  task automatic cyc(input bit s, input bit e, input bit r, input logic [31:0] d, input bit c);
    strobe = s;
    en     = e;
    rts    = r;
    data   = d;
    clr    = c;
    model_step(s, e, r, d, c);
    @(posedge clk);
    #1;
    chk("sd", {31'd0, sd}, {31'd0, m_sd});
    chk("ws", {31'd0, ws}, {31'd0, m_ws});
    chk("underrun", {31'd0, uf}, {31'd0, m_uf});
    chk("level", {28'd0, lvl}, mq.size());
    chk("rtr", {31'd0, filt_rtr}, {31'd0, (mq.size() < DEPTH)});
  endtask

  task automatic sck(input bit e);
    cyc(1, e, 0, '0, 0);
    cyc(0, e, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    strobe = 0;
    en     = 0;
    rts    = 0;
    clr    = 0;
    data   = '0;
    en_t   = 0;
    rts_t  = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sd", {31'd0, sd}, 0);
    chk("rst_ws", {31'd0, ws}, 0);
    chk("rst_underrun", {31'd0, uf}, 0);
    chk("rst_level", {28'd0, lvl}, 0);
    chk("rst_rtr", {31'd0, filt_rtr}, 1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       sd;
    logic       ws;
    logic [3:0] level;
  } vec_t;

  vec_t        tbl[N];
  logic [31:0] pat;
  logic [31:0] tf[2];
  logic [31:0] w;
  bit          re;

  initial begin
    pat = 32'hA5A53C3C;
    for (int i = 0; i < N; i++) begin
      tbl[i].sd = pat[N-1-i];
`ifdef I2SO_LEFT_JUSTIFIED_EN
      tbl[i].ws = (i >= 16);
`else
      tbl[i].ws = (i >= 15) && (i <= 30);
`endif
      tbl[i].level = 4'd0;
    end
    tf[0] = 32'h11223344;
    tf[1] = 32'hA0B0C0D0;

    // Single frame serialisation against the vector table.
    do_reset();
    cyc(0, 0, 1, 32'hA5A53C3C, 0);
    cyc(0, 0, 0, '0, 0);
    chk("a_level_before", {28'd0, lvl}, 1);
    for (int i = 0; i < N; i++) begin
      cyc(1, 1, 0, '0, 0);
      chk("a_tbl_sd", {31'd0, sd}, {31'd0, tbl[i].sd});
      chk("a_tbl_ws", {31'd0, ws}, {31'd0, tbl[i].ws});
      chk("a_tbl_level", {28'd0, lvl}, {28'd0, tbl[i].level});
      cyc(0, (i < N - 1), 0, '0, 0);
    end
    cyc(1, 0, 0, '0, 0);
    chk("a_idle_sd", {31'd0, sd}, 0);
    chk("a_idle_ws", {31'd0, ws}, 0);
    chk("a_no_underrun", {31'd0, uf}, 0);

    // Underrun, clear, and set-beats-clear.
    do_reset();
    cyc(1, 1, 0, '0, 0);
    chk("u_set", {31'd0, uf}, 1);
    for (int i = 1; i < N; i++) sck(1);
    cyc(0, 1, 0, '0, 1);
    chk("u_clr", {31'd0, uf}, 0);
    cyc(1, 1, 0, '0, 1);
    chk("u_set_over_clr", {31'd0, uf}, 1);
    for (int i = 1; i < N; i++) sck(0);
    sck(0);
    cyc(0, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) sck(0);
    chk("u_idle_no_set", {31'd0, uf}, 0);

    // Full FIFO, pop with rts held, simultaneous push/pop below full.
    do_reset();
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, $urandom, 0);
    chk("f_level_full", {28'd0, lvl}, 8);
    chk("f_rtr_low", {31'd0, filt_rtr}, 0);
    cyc(1, 1, 1, $urandom, 0);
    chk("f_pop_level", {28'd0, lvl}, 7);
    cyc(0, 1, 1, $urandom, 0);
    chk("f_refill_level", {28'd0, lvl}, 8);
    for (int i = 1; i < N; i++) sck(1);
    cyc(1, 1, 0, '0, 0);
    chk("f_second_pop", {28'd0, lvl}, 7);
    cyc(0, 1, 0, '0, 0);
    for (int i = 1; i < N; i++) sck(1);
    cyc(1, 1, 1, $urandom, 0);
    chk("f_push_pop_same", {28'd0, lvl}, 7);
    cyc(0, 0, 0, '0, 0);
    for (int i = 1; i <= N; i++) sck(0);
    chk("f_idle_ws", {31'd0, ws}, 0);

    // TDM instance: 4 x 8-bit channels, two frames back to back.
    do_reset();
    rts_t  = 1;
    data_t = tf[0];
    cyc(0, 0, 0, '0, 0);
    data_t = tf[1];
    cyc(0, 0, 0, '0, 0);
    rts_t = 0;
    cyc(0, 0, 0, '0, 0);
    chk("t_level2", {29'd0, lvl_t}, 2);
    en_t = 1;
    for (int k = 0; k < 2 * N; k++) begin
      cyc(1, 0, 0, '0, 0);
      w = tf[k / N];
      chk("t_sd", {31'd0, sd_t}, {31'd0, w[N-1-(k%N)]});
      chk("t_ws", {31'd0, ws_t}, {31'd0, exp_ws(k % N)});
      if (k == 0) chk("t_level1", {29'd0, lvl_t}, 1);
      if (k == N) begin
        chk("t_level0", {29'd0, lvl_t}, 0);
        en_t = 0;
      end
      cyc(0, 0, 0, '0, 0);
    end
    cyc(1, 0, 0, '0, 0);
    chk("t_idle_sd", {31'd0, sd_t}, 0);
    chk("t_idle_ws", {31'd0, ws_t}, 0);
    chk("t_no_underrun", {31'd0, uf_t}, 0);

    // Disable mid-frame, then asynchronous reset mid-frame.
    do_reset();
    cyc(0, 0, 1, 32'h0F0F1234, 0);
    for (int i = 0; i <= 10; i++) sck(1);
    for (int i = 11; i < N; i++) sck(0);
    cyc(1, 0, 0, '0, 0);
    chk("d_idle_sd", {31'd0, sd}, 0);
    chk("d_idle_ws", {31'd0, ws}, 0);
    cyc(0, 0, 1, 32'hFFFFFFFF, 0);
    cyc(0, 0, 1, 32'hFFFFFFFF, 0);
    for (int i = 0; i <= 5; i++) sck(1);
    chk("d_pre_rst_sd", {31'd0, sd}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("d_rst_sd", {31'd0, sd}, 0);
    chk("d_rst_ws", {31'd0, ws}, 0);
    chk("d_rst_level", {28'd0, lvl}, 0);
    model_reset();
    strobe = 0;
    en     = 0;
    rts    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sck(0);

    // Random traffic against the model.
    re = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(63) == 0) re = !re;
      cyc(($urandom_range(2) == 0), re, $urandom_range(1), $urandom, ($urandom_range(19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
